// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Used by the loader, inst_mem and PC so address widths agree.
package imem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready word stream from the host program source.
// master = host, slave = imem_loader.
interface imem_loader_if;
  import imem_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory from address 0,
// holding the core until done. IMEM_LOADER_CHECKSUM_EN adds checksum.
module imem_loader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  ld_state_t state;
  ld_state_t state_nx;
  logic      xfer;
  logic      at_end;
  logic      restart;

  assign src.in_ready = (state == LOAD);
  assign core_hold    = (state != DONE);
  assign done         = (state == DONE);

  // word_count doubles as the write pointer; it never passes DEPTH
  assign xfer    = src.in_valid & src.in_ready;
  assign at_end  = (word_count == LAST_IDX);
  assign restart = start & (state != LOAD);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: start is only honoured outside LOAD
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: if (xfer && (src.in_last || at_end)) state_nx = DONE;
      DONE: if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // registered write port and load counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      mem_we <= xfer;
      if (restart) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end else if (xfer) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= src.in_data;
        word_count <= word_count + 1'b1;
        if (at_end && !src.in_last) overflow <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // running XOR of accepted words in the current load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       checksum <= '0;
    else if (restart) checksum <= '0;
    else if (xfer)    checksum <= checksum ^ src.in_data;
  end
`endif

endmodule
